a0_trace: RTL and testbench
===========================

# a0_trace

Cycle-stamped capture stage that sits directly downstream of the pipelined core's top level and consumes its `a0` output. Every time the sampled `a0` value changes, the block records the new value and a free-running cycle timestamp in a small FIFO. The FIFO drains over a valid/ready stream to a display driver, UART or testbench monitor. Overflow is never silent: dropped events are counted and flagged.

## Interface
- `DATA_WIDTH`, default 32: width of `a0` and `out_data`.
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `TS_WIDTH`, default 16: timestamp counter width.
- `DROP_WIDTH`, default 8: dropped-event counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low (`rst`=0 resets).
- `a0` in DATA_WIDTH: core's a0 register value.
- `enable` in 1: capture enable; when 0, nothing is sampled or pushed.
- `clear` in 1: synchronous clear of `dropped` and `overflow`.
- `out_valid` out 1: FIFO head holds a valid entry.
- `out_ready` in 1: consumer accepts the head this cycle.
- `out_data` out DATA_WIDTH: head entry value.
- `out_ts` out TS_WIDTH: head entry timestamp.
- `level` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `dropped` out DROP_WIDTH: saturating count of events lost to a full FIFO.
- `overflow` out 1: sticky flag, set on the first drop.

## Operation
- **Timestamp.** `ts_q` increments every cycle from 0 after reset and wraps modulo 2^TS_WIDTH. It ignores `enable`.
- **Change detect.** `event = enable && (!primed || a0 != last_q)`.
  - On every enabled edge: `last_q <= a0` and `primed <= 1`.
  - `last_q` also updates on dropped events, so a value is never re-reported because its earlier push was dropped.
- **Push.** If `event` is true and the FIFO is not full, or it is full and a pop happens the same cycle, write `{a0, ts_q}` at the write pointer.
- **Drop.** If `event` is true, the FIFO is full and no pop happens, the entry is lost.
  - `dropped` increments, saturating at all-ones.
  - `overflow` is set.
- **Pop.** Occurs when `out_valid && out_ready`; the read pointer advances.
  - `out_ready` while empty has no effect.
  - `out_data` and `out_ts` are don't-care while `out_valid`=0. The bench must not check them then.
- **Simultaneous push and pop.**
  - Both are performed and `level` is unchanged.
  - This holds when full and when non-empty.
  - When empty, only the push occurs (pop needs `out_valid`).
- **Pointers.** The write and read pointers are $clog2(DEPTH)+1 bits, with a wrap bit.
  - `level = wptr - rptr`.
  - Full when `level == DEPTH`; empty when `level == 0`.
- **Clear.** `clear` zeroes `dropped` and `overflow` on the next edge. If a drop happens in the same cycle, `clear` wins.
- **Reset values.** Asynchronous, active-low reset produces:
  - `out_valid`=0, `level`=0, `dropped`=0, `overflow`=0.
  - `ts_q`=0, `primed`=0, `last_q`=0, both pointers 0.
  - FIFO storage is not reset.
  - A reset mid-operation discards all queued entries immediately. After release, the first enabled sample is always pushed.

## Timing
- `a0` is sampled at edge k and the entry is written at edge k. `out_valid` rises after edge k, giving 1-cycle latency.
- The head is driven combinationally from the storage array and read pointer. There is no extra read latency: the next entry is visible in the cycle after a pop.
- `level`, `dropped` and `overflow` are registered and reflect their state after edge k.
- There is no combinational path from `out_ready` to `out_valid`, `out_data` or `out_ts`.
- Throughput: one push and one pop per cycle, sustained.

## Structure
- Package `a0trace_pkg`:
  - `typedef struct packed { logic [DATA_WIDTH-1:0] value; logic [TS_WIDTH-1:0] ts; } trace_entry_t;`
  - Parameter defaults, declared as localparams.
- Sub-module `sync_fifo`:
  - Parameterised on entry type width and DEPTH.
  - Ports: push, pop, wdata, rdata, level, full, empty.
  - Same `clk`/`rst` convention.
- The `a0_trace` top holds the timestamp counter, change detector, drop counter and stream glue.

## Test plan
- **Reset.** Assert `rst`=0 mid-run with 3 entries queued. Required: `out_valid`=0 and `level`=0 asynchronously, before the next edge. After release, `dropped`=0.
- **First sample and change detect.** Use `enable`=1 and `out_ready`=0, and hold `a0`=0x0 for 5 cycles starting at cycle 0, then set `a0`=0x5 at cycle 5. Required: `level`=2, with entries {0x0, ts 0} and {0x5, ts 5}. Unchanged cycles push nothing.
- **Overflow.** Use DEPTH=8 and `out_ready`=0, and apply 11 distinct `a0` values on consecutive cycles. Required:
  - `level`=8, holding the first 8 values.
  - `dropped`=3 and `overflow`=1.
  - Then raise `out_ready`, change `a0` to a 12th value and pulse `clear`. Required: the 12th value is pushed and is not a re-report of value 11; `dropped`=0 and `overflow`=0.
- **Full plus simultaneous push/pop.** With the FIFO full, `out_ready`=1, and a new `a0` value. Required: `level` stays 8, the head advances, the new value becomes the tail, and `dropped` does not increment.
- **Drain order and back-pressure.** Use a random `out_ready` pattern over 100 random `a0` changes. Required: the output sequence equals the input change sequence in order, accounting for drops, and timestamps strictly increase modulo 2^TS_WIDTH.
- **Timestamp wrap.** Use TS_WIDTH=4 and change `a0` at cycles 14, 15, 16 and 17. Required: timestamps 14, 15, 0, 1.

Source files
------------

// File: rtl/a0trace_pkg.sv
// Shared defaults and the trace record layout for the a0 capture stage.
package a0trace_pkg;

  localparam int unsigned A0T_DATA_WIDTH = 32;
  localparam int unsigned A0T_DEPTH      = 8;
  localparam int unsigned A0T_TS_WIDTH   = 16;
  localparam int unsigned A0T_DROP_WIDTH = 8;

  typedef struct packed {
    logic [A0T_DATA_WIDTH-1:0] value;
    logic [A0T_TS_WIDTH-1:0]   ts;
  } trace_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a combinational head.
module sync_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  always_comb begin
    level   = wptr_q - rptr_q;
    full    = (level == FULL_LEVEL);
    empty   = (level == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = do_push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = do_pop  ? rptr_q + PTR_ONE : rptr_q;
    rdata   = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/a0_trace.sv
// Captures a0 value changes with a cycle timestamp and streams them out of a FIFO.
module a0_trace
  import a0trace_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = A0T_DATA_WIDTH,
  parameter int unsigned DEPTH      = A0T_DEPTH,
  parameter int unsigned TS_WIDTH   = A0T_TS_WIDTH,
  parameter int unsigned DROP_WIDTH = A0T_DROP_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   a0,
  input  logic                    enable,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [TS_WIDTH-1:0]     out_ts,
  output logic [$clog2(DEPTH):0]  level,
  output logic [DROP_WIDTH-1:0]   dropped,
  output logic                    overflow
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] value;
    logic [TS_WIDTH-1:0]   ts;
  } entry_t;

  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic                  primed_q, primed_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [DROP_WIDTH-1:0] dropped_q, dropped_d;
  logic                  overflow_q, overflow_d;
  logic                  evt, push, pop, drop, full, empty;
  entry_t                wentry, rentry;

  // last_q follows every enabled sample, dropped or not, so a lost value is never re-reported.
  always_comb begin
    evt        = enable && (!primed_q || (a0 != last_q));
    pop        = !empty && out_ready;
    push       = evt && (!full || pop);
    drop       = evt && full && !pop;
    ts_d       = ts_q + TS_WIDTH'(1);
    primed_d   = enable ? 1'b1 : primed_q;
    last_d     = enable ? a0 : last_q;
    dropped_d  = dropped_q;
    overflow_d = overflow_q;
    if (clear) begin
      dropped_d  = '0;
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (dropped_q != '1) dropped_d = dropped_q + DROP_WIDTH'(1);
    end
    wentry.value = a0;
    wentry.ts    = ts_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q       <= '0;
      primed_q   <= 1'b0;
      last_q     <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      primed_q   <= primed_d;
      last_q     <= last_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + TS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (rentry),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_data  = rentry.value;
  assign out_ts    = rentry.ts;
  assign dropped   = dropped_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_a0_trace.sv
// Self-checking bench for a0_trace: queue-based reference model plus directed vectors.
module tb_a0_trace;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a0 = '0;
  logic        enable = 1'b0, clear = 1'b0, out_ready = 1'b0;
  logic        out_valid, overflow;
  logic [31:0] out_data;
  logic [15:0] out_ts;
  logic [3:0]  level;
  logic [7:0]  dropped;

  logic        rst_w = 1'b0;
  logic [31:0] a0_w = '0;
  logic        enable_w = 1'b0, out_ready_w = 1'b0;
  logic        out_valid_w, overflow_w;
  logic [31:0] out_data_w;
  logic [3:0]  out_ts_w;
  logic [3:0]  level_w;
  logic [7:0]  dropped_w;

  a0_trace #(.DATA_WIDTH(32), .DEPTH(DEPTH), .TS_WIDTH(16), .DROP_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .a0(a0), .enable(enable), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ts(out_ts),
    .level(level), .dropped(dropped), .overflow(overflow));

  a0_trace #(.DATA_WIDTH(32), .DEPTH(DEPTH), .TS_WIDTH(4), .DROP_WIDTH(8)) dut_w (
    .clk(clk), .rst(rst_w), .a0(a0_w), .enable(enable_w), .clear(1'b0),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w), .out_ts(out_ts_w),
    .level(level_w), .dropped(dropped_w), .overflow(overflow_w));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic [15:0] t;
  } ent_t;

  typedef struct {
    logic [31:0] a0;
    logic        en, rdy, clr;
    logic [3:0]  lvl;
    logic        vld;
  } vec_t;

  ent_t        mq[$];
  logic [15:0] m_ts;
  logic        m_primed;
  logic [31:0] m_last;
  logic [7:0]  m_drop;
  logic        m_ovf;
  int unsigned n_cmp = 0, n_mis = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ts = '0; m_primed = 1'b0; m_last = '0; m_drop = '0; m_ovf = 1'b0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cyc(input logic [31:0] v, input logic en, input logic rdy, input logic clr);
    logic pop, evt, full, drp;
    a0 = v; enable = en; out_ready = rdy; clear = clr;
    #1;
    chk("out_valid", out_valid, mq.size() != 0);
    pop  = (mq.size() != 0) && rdy;
    evt  = en && (!m_primed || v != m_last);
    full = (mq.size() == DEPTH);
    drp  = 1'b0;
    if (pop) begin
      chk("head_data", out_data, mq[0].v);
      chk("head_ts", out_ts, mq[0].t);
      void'(mq.pop_front());
    end
    if (evt) begin
      if (!full || pop) mq.push_back('{v: v, t: m_ts});
      else drp = 1'b1;
    end
    if (en) begin m_last = v; m_primed = 1'b1; end
    if (clr) begin m_drop = '0; m_ovf = 1'b0; end
    else if (drp) begin
      m_ovf = 1'b1;
      if (m_drop != 8'hFF) m_drop++;
    end
    m_ts++;
    @(posedge clk);
    @(negedge clk);
    chk("level", level, mq.size());
    chk("dropped", dropped, m_drop);
    chk("overflow", overflow, m_ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[12];
    logic [3:0]  wexp_ts[4];
    logic [31:0] wexp_d[4];
    logic [31:0] rv;

    vt[0]  = '{32'h0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1};
    vt[1]  = '{32'h0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1};
    vt[2]  = '{32'h0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1};
    vt[3]  = '{32'h0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1};
    vt[4]  = '{32'h0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1};
    vt[5]  = '{32'h5, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1};
    vt[6]  = '{32'h9, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1};
    vt[7]  = '{32'h9, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1};
    vt[8]  = '{32'h9, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    vt[9]  = '{32'h9, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    vt[10] = '{32'h5, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vt[11] = '{32'h9, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1};

    // Timestamp wrap on the 4-bit instance while the main instance sits in reset.
    repeat (2) @(negedge clk);
    rst_w = 1'b1;
    for (int k = 0; k < 18; k++) begin
      enable_w = (k >= 14);
      a0_w = 32'd7 + 32'd3 * k;
      if (k >= 14) begin
        wexp_d[k-14]  = a0_w;
        wexp_ts[k-14] = 4'(k);
      end
      @(negedge clk);
    end
    enable_w = 1'b0;
    chk("wrap_level", level_w, 4);
    for (int j = 0; j < 4; j++) begin
      out_ready_w = 1'b1;
      #1;
      chk("wrap_valid", out_valid_w, 1);
      chk("wrap_ts", out_ts_w, wexp_ts[j]);
      chk("wrap_data", out_data_w, wexp_d[j]);
      @(negedge clk);
    end
    out_ready_w = 1'b0;
    chk("wrap_empty", level_w, 0);

    // Reset state, then release on a falling edge so the next rising edge is cycle 0.
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b1;
    model_reset();

    for (int i = 0; i < 12; i++) begin
      cyc(vt[i].a0, vt[i].en, vt[i].rdy, vt[i].clr);
      chk("vec_level", level, vt[i].lvl);
      chk("vec_valid", out_valid, vt[i].vld);
    end
    cyc(32'h9, 1'b0, 1'b1, 1'b0);

    // Overflow: 11 distinct values into an 8-deep FIFO with no consumer.
    for (int i = 0; i < 11; i++) cyc(32'h100 + i, 1'b1, 1'b0, 1'b0);
    chk("ovf_level", level, 8);
    chk("ovf_dropped", dropped, 3);
    chk("ovf_flag", overflow, 1);
    cyc(32'h200, 1'b1, 1'b1, 1'b1);
    chk("clr_dropped", dropped, 0);
    chk("clr_flag", overflow, 0);
    chk("clr_level", level, 8);

    // Full with simultaneous push and pop.
    cyc(32'h300, 1'b1, 1'b1, 1'b0);
    chk("fullpp_level", level, 8);
    chk("fullpp_dropped", dropped, 0);

    // Clear wins over a same-cycle drop.
    cyc(32'h301, 1'b1, 1'b0, 1'b1);
    chk("clrwin_dropped", dropped, 0);
    chk("clrwin_flag", overflow, 0);
    cyc(32'h302, 1'b1, 1'b0, 1'b0);
    chk("drop1", dropped, 1);

    // Drop counter saturates at all-ones.
    for (int i = 0; i < 260; i++) cyc(32'h400 + i, 1'b1, 1'b0, 1'b0);
    chk("sat_dropped", dropped, 8'hFF);
    chk("sat_flag", overflow, 1);
    cyc(32'h400, 1'b0, 1'b0, 1'b1);
    chk("sat_clear", dropped, 0);

    for (int i = 0; i < 10; i++) cyc(32'h0, 1'b0, 1'b1, 1'b0);
    chk("drain_level", level, 0);

    // Random back-pressure over 100 value changes.
    rv = 32'h1000;
    for (int i = 0; i < 100; i++) begin
      rv = rv + 32'd1 + 32'($urandom_range(0, 7));
      cyc(rv, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 12; i++) cyc(rv, 1'b0, 1'b1, 1'b0);
    chk("rand_empty", level, 0);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) cyc(32'h500 + i, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_level", level, 3);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_level", level, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    chk("post_rst_dropped", dropped, 0);
    cyc(32'h0, 1'b1, 1'b0, 1'b0);
    chk("first_after_rst", level, 1);
    cyc(32'h0, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
